ifetch_unit: RTL and testbench

Instruction fetch stage that produces the 32-bit instruction word consumed by the combinational instruction decoder (IR_circuit). It owns the PC, issues word requests to instruction memory over a req/ready handshake, latches the returned word into the IR register, and presents IR plus its PC with a valid flag. It supports decode-side stall, a one-entry skid buffer, and branch/jump redirect with discard of in-flight fetches.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/ifetch_unit_if.sv | 14 +
 rtl/ifetch_skid.sv | 35 +++
 rtl/ifetch_unit.sv | 136 +++++++++++++
 tb/tb_ifetch_unit.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: word geometry, reset PC
// and the fetch FSM state encoding.
package mips_pkg;

    localparam int WORD_W      = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [WORD_W-1:0] PC_STEP          = WORD_W'(INSTR_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    // Instruction addresses are always word aligned; the low bits are dropped.
    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave).
interface ifetch_unit_if;
    import mips_pkg::*;

    logic              req;
    logic [WORD_W-1:0] addr;
    logic              ready;
    logic [WORD_W-1:0] rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);

endinterface

// File: rtl/ifetch_skid.sv
// One-entry holding buffer for a fetched {pc, instr} pair that arrived
// while decode was stalled.
module ifetch_skid
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [WORD_W-1:0] push_pc,
    input  logic [WORD_W-1:0] push_instr,
    output logic              valid,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] instr
);

    // A push on the same edge as a pop replaces the entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (push) begin
            valid <= 1'b1;
            pc    <= push_pc;
            instr <= push_instr;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words from instruction memory
// and presents them in IR with stall, skid buffering and redirect flush.
module ifetch_unit
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    ifetch_unit_if.master     imem,
    input  logic              stall,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic [WORD_W-1:0] ir,
    output logic [WORD_W-1:0] ir_pc,
    output logic              ir_valid
);

    fetch_state_t      state, state_next;
    logic [WORD_W-1:0] pc, pc_next;
    logic [WORD_W-1:0] addr_q, addr_next;
    logic [WORD_W-1:0] target;

    logic accept, slot_free, live_word, load_from_mem;
    logic skid_push, skid_pop, skid_empty_next;

    logic              skid_valid;
    logic [WORD_W-1:0] skid_pc, skid_instr;

    assign imem.req  = (state != IDLE);
    assign imem.addr = addr_q;

    assign target    = word_align(redirect_pc);
    assign accept    = imem.req && imem.ready;
    assign slot_free = !ir_valid || !stall;

    // Only a response to a REQ-state fetch with no redirect is a live word;
    // a parked skid entry always reaches IR before a fresh memory word.
    assign live_word       = accept && (state == REQ) && !redirect;
    assign skid_pop        = !redirect && slot_free && skid_valid;
    assign load_from_mem   = live_word && slot_free && !skid_valid;
    assign skid_push       = live_word && !load_from_mem;
    assign skid_empty_next = redirect || (!skid_push && (!skid_valid || skid_pop));

    ifetch_skid u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (skid_push),
        .pop        (skid_pop),
        .flush      (redirect),
        .push_pc    (addr_q),
        .push_instr (imem.rdata),
        .valid      (skid_valid),
        .pc         (skid_pc),
        .instr      (skid_instr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            addr_q <= '0;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            addr_q <= addr_next;
        end
    end

    // A request stays on the bus until accepted, even when it became stale.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        addr_next  = addr_q;
        if (redirect) begin
            pc_next = target;
        end
        case (state)
            IDLE: begin
                if (redirect) begin
                    state_next = REQ;
                    addr_next  = target;
                end else if (skid_empty_next) begin
                    state_next = REQ;
                    addr_next  = pc;
                end
            end
            REQ: begin
                if (redirect) begin
                    if (accept) begin
                        addr_next = target;
                    end else begin
                        state_next = DROP;
                    end
                end else if (accept) begin
                    pc_next = pc + PC_STEP;
                    if (skid_empty_next) begin
                        addr_next = pc + PC_STEP;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DROP: begin
                if (accept) begin
                    state_next = REQ;
                    addr_next  = redirect ? target : pc;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
        end else if (redirect) begin
            ir_valid <= 1'b0;
        end else if (skid_pop) begin
            ir       <= skid_instr;
            ir_pc    <= skid_pc;
            ir_valid <= 1'b1;
        end else if (load_from_mem) begin
            ir       <= imem.rdata;
            ir_pc    <= addr_q;
            ir_valid <= 1'b1;
        end else if (ir_valid && !stall) begin
            ir_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed walk through the fetch scenarios followed by a randomized run
// scored against an in-order instruction stream model.
module tb_ifetch_unit;
    import mips_pkg::*;

    localparam int RAND_CYCLES = 3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] ir, ir_pc;
    logic        ir_valid;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_pc, prev_addr, prev_ir, prev_ir_pc, rand_pc, first_target;
    logic        prev_wait, prev_stalled, have_prev, rnd_ready, rnd_stall, rnd_redirect;
    int          consumed, idle_run, max_idle;

    ifetch_unit_if bus ();

    ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (bus),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .ir_valid    (ir_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h00:  return 32'h0000_0820;
            32'h04:  return 32'h2002_000a;
            32'h08:  return 32'h2403_000a;
            32'h0C:  return 32'h0043_2021;
            32'h10:  return 32'h0044_2824;
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    assign bus.rdata = mem_word(bus.addr);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rdy, input logic st, input logic rd, input logic [31:0] rpc);
        bus.ready   = rdy;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        #2;
        checkOutput("rst_req", bus.req, 1'b0);
        checkOutput("rst_addr", bus.addr, 32'h0);
        checkOutput("rst_ir", ir, 32'h0);
        checkOutput("rst_ir_pc", ir_pc, 32'h0);
        checkOutput("rst_valid", ir_valid, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        checkOutput("c0_idle", bus.req, 1'b0);

        // Zero-wait streaming from reset.
        tick();
        checkOutput("c1_req", bus.req, 1'b1);
        checkOutput("c1_addr", bus.addr, 32'h0);
        tick();
        checkOutput("zw_ir0", ir, 32'h0000_0820);
        checkOutput("zw_pc0", ir_pc, 32'h0);
        checkOutput("zw_v0", ir_valid, 1'b1);
        tick();
        checkOutput("zw_ir1", ir, 32'h2002_000a);
        tick();
        checkOutput("zw_ir2", ir, 32'h2403_000a);
        checkOutput("zw_pc2", ir_pc, 32'h8);

        // Stall for three cycles: the next word parks in the skid buffer.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput($sformatf("stall_ir_%0d", k), ir, 32'h2403_000a);
            checkOutput($sformatf("stall_v_%0d", k), ir_valid, 1'b1);
            checkOutput($sformatf("stall_req_%0d", k), bus.req, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("skid_ir", ir, 32'h0043_2021);
        checkOutput("skid_pc", ir_pc, 32'hC);
        checkOutput("refetch_addr", bus.addr, 32'h10);
        tick();
        checkOutput("post_skid_ir", ir, 32'h0044_2824);
        checkOutput("post_skid_v", ir_valid, 1'b1);

        // Asynchronous reset while a request waits.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("wait_req", bus.req, 1'b1);
        checkOutput("wait_addr", bus.addr, 32'h14);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("arst_req", bus.req, 1'b0);
        checkOutput("arst_ir", ir, 32'h0);
        checkOutput("arst_v", ir_valid, 1'b0);
        checkOutput("arst_addr", bus.addr, 32'h0);
        tick();
        rst_n = 1'b1;

        // Wait states: request held three cycles before ready.
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput($sformatf("ws_req_%0d", k), bus.req, 1'b1);
            checkOutput($sformatf("ws_addr_%0d", k), bus.addr, 32'h0);
            checkOutput($sformatf("ws_v_%0d", k), ir_valid, 1'b0);
        end
        bus.ready = 1'b1;
        tick();
        checkOutput("ws_ir", ir, 32'h0000_0820);
        checkOutput("ws_v", ir_valid, 1'b1);

        // Redirect while the fetch of 0x8 is outstanding.
        tick();
        checkOutput("pre_rd_ir", ir, 32'h2002_000a);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("pre_rd_addr", bus.addr, 32'h8);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h40);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("drop_v", ir_valid, 1'b0);
        checkOutput("drop_req", bus.req, 1'b1);
        checkOutput("drop_addr", bus.addr, 32'h8);
        tick();
        checkOutput("drop_discard_v", ir_valid, 1'b0);
        checkOutput("drop_new_addr", bus.addr, 32'h40);
        tick();
        checkOutput("rd_ir", ir, mem_word(32'h40));
        checkOutput("rd_pc", ir_pc, 32'h40);

        // Redirect during stall to an unaligned target flushes the skid.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        checkOutput("st_rd_hold", ir_pc, 32'h40);
        checkOutput("st_rd_req", bus.req, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h42);
        tick();
        checkOutput("st_rd_v", ir_valid, 1'b0);
        checkOutput("st_rd_addr", bus.addr, 32'h40);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("st_rd_pc", ir_pc, 32'h40);
        checkOutput("st_rd_ir", ir, mem_word(32'h40));

        // PC wrap at the top of the address space.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
        tick();
        checkOutput("wrap_addr", bus.addr, 32'hFFFF_FFFC);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("wrap_pc_top", ir_pc, 32'hFFFF_FFFC);
        tick();
        checkOutput("wrap_pc_zero", ir_pc, 32'h0);
        checkOutput("wrap_ir_zero", ir, 32'h0000_0820);

        // Randomized run: consumed words must form the program-order stream.
        have_prev    = 1'b0;
        prev_wait    = 1'b0;
        prev_stalled = 1'b0;
        prev_addr    = 32'h0;
        prev_ir      = 32'h0;
        prev_ir_pc   = 32'h0;
        consumed     = 0;
        idle_run     = 0;
        max_idle     = 0;
        exp_pc       = 32'h0;
        first_target = $urandom & 32'h0000_0FFF;
        for (int i = 0; i < RAND_CYCLES; i++) begin
            if (have_prev && prev_wait) begin
                checkOutput("r_hold_req", bus.req, 1'b1);
                checkOutput("r_hold_addr", bus.addr, prev_addr);
            end
            if (have_prev && prev_stalled) begin
                checkOutput("r_stall_v", ir_valid, 1'b1);
                checkOutput("r_stall_ir", ir, prev_ir);
                checkOutput("r_stall_pc", ir_pc, prev_ir_pc);
            end
            if (ir_valid) checkOutput("r_ir_word", ir, mem_word(ir_pc));
            if (bus.req) checkOutput("r_addr_align", {30'h0, bus.addr[1:0]}, 32'h0);

            rnd_ready    = ($urandom_range(0, 9) < 7);
            rnd_stall    = ($urandom_range(0, 9) < 3);
            rnd_redirect = (i == 0) || ($urandom_range(0, 19) == 0);
            rand_pc      = (i == 0) ? first_target :
                           ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) :
                           32'($urandom);
            applyStimulus(rnd_ready, rnd_stall, rnd_redirect, rand_pc);

            if (rnd_redirect) begin
                exp_pc   = rand_pc & ~32'h3;
                idle_run = 0;
            end else if (ir_valid && !rnd_stall) begin
                checkOutput("r_stream_pc", ir_pc, exp_pc);
                exp_pc   = exp_pc + 32'd4;
                consumed++;
                idle_run = 0;
            end else begin
                idle_run++;
                if (idle_run > max_idle) max_idle = idle_run;
            end

            prev_wait    = bus.req && !rnd_ready;
            prev_addr    = bus.addr;
            prev_stalled = ir_valid && rnd_stall && !rnd_redirect;
            prev_ir      = ir;
            prev_ir_pc   = ir_pc;
            have_prev    = 1'b1;
            tick();
        end
        checkOutput("r_progress_gap", (max_idle <= 60), 1'b1);
        checkOutput("r_consumed_min", (consumed > RAND_CYCLES / 8), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
